// File: rtl/vending_txn_ctrl_pkg.sv
// Shared widths, state encoding and coin/price tables for the vending transaction controller.
package vending_txn_ctrl_pkg;

    localparam int kNumCoins  = 3;
    localparam int kNumItems  = 4;
    localparam int kTotalBits = 31;
    localparam int kTimerBits = 32;
    localparam logic [kTimerBits-1:0] kWaitTime = 32'd100;

    typedef logic [kTotalBits-1:0] total_t;
    typedef logic [1:0]            coin_idx_t;
    typedef logic [1:0]            item_idx_t;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COLLECT = 2'd1,
        S_CHANGE  = 2'd2
    } state_e;

    // Coin values ascend with index, so the change search can scan upward and keep the last fit.
    function automatic total_t coinValue(input coin_idx_t idx);
        case (idx)
            2'd0:    coinValue = total_t'(100);
            2'd1:    coinValue = total_t'(500);
            default: coinValue = total_t'(1000);
        endcase
    endfunction

    function automatic total_t itemPrice(input item_idx_t idx);
        case (idx)
            2'd0:    itemPrice = total_t'(400);
            2'd1:    itemPrice = total_t'(500);
            2'd2:    itemPrice = total_t'(1000);
            default: itemPrice = total_t'(2000);
        endcase
    endfunction

endpackage

// File: rtl/vending_txn_ctrl_if.sv
// Coin/select/return inputs and item/coin/status outputs of the vending transaction controller.
interface vending_txn_ctrl_if;
    import vending_txn_ctrl_pkg::*;

    logic [kNumCoins-1:0]  i_input_coin;
    logic [kNumItems-1:0]  i_select_item;
    logic                  i_trigger_return;
    logic [kNumItems-1:0]  o_available_item;
    logic [kNumItems-1:0]  o_output_item;
    logic [kNumCoins-1:0]  o_return_coin;
    logic                  o_coin_reject;
    logic [kTotalBits-1:0] o_current_total;
    logic                  o_busy;

    modport master (
        output i_input_coin, i_select_item, i_trigger_return,
        input  o_available_item, o_output_item, o_return_coin, o_coin_reject,
               o_current_total, o_busy
    );

    modport slave (
        input  i_input_coin, i_select_item, i_trigger_return,
        output o_available_item, o_output_item, o_return_coin, o_coin_reject,
               o_current_total, o_busy
    );

endinterface

// File: rtl/vending_txn_ctrl_wait_timer.sv
// Inactivity timer: reloadable down counter that saturates at zero, with clear taking priority.
module vending_txn_ctrl_wait_timer
    import vending_txn_ctrl_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic clear_i,
    input  logic load_i,
    input  logic en_i,
    output logic zero_o
);

    logic [kTimerBits-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (load_i) begin
            count_d = kWaitTime;
        end else if (en_i && (count_q != '0)) begin
            count_d = count_q - kTimerBits'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign zero_o = (count_q == '0);

endmodule

// File: rtl/vending_txn_ctrl.sv
// Transaction sequencer: owns the credit total, the wait timer and the IDLE/COLLECT/CHANGE FSM;
// dispenses items and pays change one coin per cycle, largest denomination first.
module vending_txn_ctrl
    import vending_txn_ctrl_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    vending_txn_ctrl_if.slave  bus
);

    state_e                 state_q, state_d;
    total_t                 total_q, total_d;
    logic [kNumItems-1:0]   item_q, item_d;
    logic [kNumCoins-1:0]   retCoin_q, retCoin_d;
    logic                   reject_q, reject_d;
    logic [kNumItems-1:0]   avail;
    logic                   timerClear, timerLoad, timerEn, timerZero;

    logic                   coinValid, selValid, changeValid, dispenseOk, coinFits;
    coin_idx_t              coinIdx, changeIdx;
    item_idx_t              selIdx;
    total_t                 coinVal, selPrice, collectTotal, changeTotal;
    logic [kTotalBits:0]    afterDispense, sumWide;

    vending_txn_ctrl_wait_timer u_timer (
        .clk     (clk),
        .reset   (reset),
        .clear_i (timerClear),
        .load_i  (timerLoad),
        .en_i    (timerEn),
        .zero_o  (timerZero)
    );

    // Input decode and credit arithmetic; the extra top bit of sumWide flags an overflowing coin.
    always_comb begin
        coinValid = |bus.i_input_coin;
        coinIdx   = '0;
        for (int i = kNumCoins - 1; i >= 0; i--) begin
            if (bus.i_input_coin[i]) coinIdx = coin_idx_t'(i);
        end
        selValid = |bus.i_select_item;
        selIdx   = '0;
        for (int i = kNumItems - 1; i >= 0; i--) begin
            if (bus.i_select_item[i]) selIdx = item_idx_t'(i);
        end
        changeValid = 1'b0;
        changeIdx   = '0;
        for (int i = 0; i < kNumCoins; i++) begin
            if (coinValue(coin_idx_t'(i)) <= total_q) begin
                changeValid = 1'b1;
                changeIdx   = coin_idx_t'(i);
            end
        end
        coinVal       = coinValue(coinIdx);
        selPrice      = itemPrice(selIdx);
        dispenseOk    = selValid && (selPrice <= total_q);
        afterDispense = {1'b0, total_q} - (dispenseOk ? {1'b0, selPrice} : '0);
        sumWide       = afterDispense + {1'b0, coinVal};
        coinFits      = coinValid && !sumWide[kTotalBits];
        collectTotal  = coinFits ? sumWide[kTotalBits-1:0] : afterDispense[kTotalBits-1:0];
        changeTotal   = total_q - coinValue(changeIdx);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (coinValid) state_d = S_COLLECT;
            end
            S_COLLECT: begin
                if (bus.i_trigger_return || timerZero) begin
                    state_d = S_CHANGE;
                end else if (collectTotal == '0) begin
                    state_d = S_IDLE;
                end
            end
            S_CHANGE: begin
                if (!changeValid || (changeTotal == '0)) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Return and timeout take priority over dispensing; a coin arriving then is bounced.
    always_comb begin
        total_d    = total_q;
        item_d     = '0;
        retCoin_d  = '0;
        reject_d   = 1'b0;
        timerClear = 1'b0;
        timerLoad  = 1'b0;
        timerEn    = 1'b0;
        avail      = '0;
        case (state_q)
            S_IDLE: begin
                if (coinValid) begin
                    total_d   = coinVal;
                    timerLoad = 1'b1;
                end else begin
                    timerClear = 1'b1;
                end
            end
            S_COLLECT: begin
                for (int i = 0; i < kNumItems; i++) begin
                    avail[i] = (itemPrice(item_idx_t'(i)) <= total_q);
                end
                if (bus.i_trigger_return || timerZero) begin
                    reject_d   = coinValid;
                    timerClear = 1'b1;
                end else begin
                    if (dispenseOk) item_d[selIdx] = 1'b1;
                    reject_d = coinValid && !coinFits;
                    total_d  = collectTotal;
                    if (collectTotal == '0) begin
                        timerClear = 1'b1;
                    end else if (dispenseOk || coinFits) begin
                        timerLoad = 1'b1;
                    end else begin
                        timerEn = 1'b1;
                    end
                end
            end
            S_CHANGE: begin
                reject_d   = coinValid;
                timerClear = 1'b1;
                if (changeValid) begin
                    retCoin_d[changeIdx] = 1'b1;
                    total_d              = changeTotal;
                end
            end
            default: begin
                total_d    = '0;
                timerClear = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            total_q   <= '0;
            item_q    <= '0;
            retCoin_q <= '0;
            reject_q  <= 1'b0;
        end else begin
            total_q   <= total_d;
            item_q    <= item_d;
            retCoin_q <= retCoin_d;
            reject_q  <= reject_d;
        end
    end

    assign bus.o_available_item = avail;
    assign bus.o_output_item    = item_q;
    assign bus.o_return_coin    = retCoin_q;
    assign bus.o_coin_reject    = reject_q;
    assign bus.o_current_total  = total_q;
    assign bus.o_busy           = (state_q == S_CHANGE);

endmodule

// File: tb/tb_vending_txn_ctrl.sv
// Scoreboard bench for vending_txn_ctrl: each driven cycle queues the outputs expected after the
// following rising edge, and a monitor pops and compares them just after that edge.
module tb_vending_txn_ctrl;
    import vending_txn_ctrl_pkg::*;

    typedef struct packed {
        logic [3:0]  item;
        logic [2:0]  coin;
        logic        reject;
        logic [30:0] total;
        logic        busy;
        logic [3:0]  avail;
    } exp_t;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;
    exp_t  sb[$];
    string tagQ[$];
    exp_t  monE;
    string monTag;

    vending_txn_ctrl_if bus();

    vending_txn_ctrl dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
        end
    endtask

    function automatic logic [3:0] availOf(input logic [30:0] t);
        availOf = {t >= 31'd2000, t >= 31'd1000, t >= 31'd500, t >= 31'd400};
    endfunction

    // Drive one cycle of inputs and queue what the outputs must look like after the next edge.
    task automatic applyStimulus(input string tag, input logic rst, input logic [2:0] coin,
                                 input logic [3:0] sel, input logic ret, input logic [3:0] item,
                                 input logic [2:0] rcoin, input logic rej, input logic [30:0] total,
                                 input logic busy, input logic collect);
        exp_t e;
        @(negedge clk);
        reset                = rst;
        bus.i_input_coin     = coin;
        bus.i_select_item    = sel;
        bus.i_trigger_return = ret;
        e.item   = item;
        e.coin   = rcoin;
        e.reject = rej;
        e.total  = total;
        e.busy   = busy;
        e.avail  = collect ? availOf(total) : 4'b0000;
        sb.push_back(e);
        tagQ.push_back(tag);
    endtask

    task automatic step(input string tag, input logic [2:0] coin, input logic [3:0] sel,
                        input logic ret, input logic [3:0] item, input logic [2:0] rcoin,
                        input logic rej, input logic [30:0] total, input logic busy,
                        input logic collect);
        applyStimulus(tag, 1'b0, coin, sel, ret, item, rcoin, rej, total, busy, collect);
    endtask

    task automatic idle(input string tag, input logic [30:0] total, input logic busy,
                        input logic collect);
        applyStimulus(tag, 1'b0, 3'b000, 4'b0000, 1'b0, 4'b0000, 3'b000, 1'b0, total, busy, collect);
    endtask

    always @(posedge clk) begin
        #1;
        if (sb.size() > 0) begin
            monE   = sb.pop_front();
            monTag = tagQ.pop_front();
            checkOutput({monTag, ".item"},   32'(bus.o_output_item),    32'(monE.item));
            checkOutput({monTag, ".coin"},   32'(bus.o_return_coin),    32'(monE.coin));
            checkOutput({monTag, ".reject"}, 32'(bus.o_coin_reject),    32'(monE.reject));
            checkOutput({monTag, ".total"},  32'(bus.o_current_total),  32'(monE.total));
            checkOutput({monTag, ".busy"},   32'(bus.o_busy),           32'(monE.busy));
            checkOutput({monTag, ".avail"},  32'(bus.o_available_item), 32'(monE.avail));
        end
    end

    initial begin
        bus.i_input_coin     = '0;
        bus.i_select_item    = '0;
        bus.i_trigger_return = 1'b0;

        applyStimulus("reset", 1'b1, 3'b000, 4'b0000, 1'b0, 4'b0000, 3'b000, 1'b0, 0, 1'b0, 1'b0);
        idle("reset.idle", 0, 0, 0);
        step("idle.selRet", 3'b000, 4'b0001, 1'b1, 4'b0000, 3'b000, 1'b0, 0, 0, 0);

        // Buy item1 with multiple select bits (lowest wins), then return the 1000 left.
        step("t2.c1000", 3'b100, 4'b0000, 1'b0, 4'b0000, 3'b000, 1'b0, 1000, 0, 1);
        step("t2.c500",  3'b010, 4'b0000, 1'b0, 4'b0000, 3'b000, 1'b0, 1500, 0, 1);
        step("t2.sel",   3'b000, 4'b1010, 1'b0, 4'b0010, 3'b000, 1'b0, 1000, 0, 1);
        idle("t2.hold", 1000, 0, 1);
        step("t2.ret",   3'b000, 4'b0000, 1'b1, 4'b0000, 3'b000, 1'b0, 1000, 1, 0);
        step("t2.chg",   3'b000, 4'b0000, 1'b0, 4'b0000, 3'b100, 1'b0, 0, 0, 0);
        idle("t2.idle", 0, 0, 0);

        // 1600 returned as 1000, 500, 100; the 3'b101 coin counts as a 100.
        step("t3.c1000", 3'b100, 4'b0000, 1'b0, 4'b0000, 3'b000, 1'b0, 1000, 0, 1);
        step("t3.c500",  3'b010, 4'b0000, 1'b0, 4'b0000, 3'b000, 1'b0, 1500, 0, 1);
        step("t3.c100",  3'b101, 4'b0000, 1'b0, 4'b0000, 3'b000, 1'b0, 1600, 0, 1);
        step("t3.ret",   3'b000, 4'b0000, 1'b1, 4'b0000, 3'b000, 1'b0, 1600, 1, 0);
        step("t3.chg0",  3'b000, 4'b0000, 1'b0, 4'b0000, 3'b100, 1'b0, 600, 1, 0);
        step("t3.chg1",  3'b000, 4'b0000, 1'b0, 4'b0000, 3'b010, 1'b0, 100, 1, 0);
        step("t3.chg2",  3'b000, 4'b0000, 1'b0, 4'b0000, 3'b001, 1'b0, 0, 0, 0);
        idle("t3.idle", 0, 0, 0);

        // Reset while 1500 is waiting to be paid out.
        step("t1.c1000", 3'b100, 4'b0000, 1'b0, 4'b0000, 3'b000, 1'b0, 1000, 0, 1);
        step("t1.c500",  3'b010, 4'b0000, 1'b0, 4'b0000, 3'b000, 1'b0, 1500, 0, 1);
        step("t1.ret",   3'b000, 4'b0000, 1'b1, 4'b0000, 3'b000, 1'b0, 1500, 1, 0);
        applyStimulus("t1.rst", 1'b1, 3'b000, 4'b0000, 1'b0, 4'b0000, 3'b000, 1'b0, 0, 1'b0, 1'b0);
        idle("t1.after0", 0, 0, 0);
        idle("t1.after1", 0, 0, 0);

        // Coin during CHANGE and coin alongside return are both bounced.
        step("t6.c1000", 3'b100, 4'b0000, 1'b0, 4'b0000, 3'b000, 1'b0, 1000, 0, 1);
        step("t6.c500",  3'b010, 4'b0000, 1'b0, 4'b0000, 3'b000, 1'b0, 1500, 0, 1);
        step("t6.ret",   3'b000, 4'b0000, 1'b1, 4'b0000, 3'b000, 1'b0, 1500, 1, 0);
        step("t6.rejChg",3'b010, 4'b0000, 1'b0, 4'b0000, 3'b100, 1'b1, 500, 1, 0);
        step("t6.chg1",  3'b000, 4'b0000, 1'b0, 4'b0000, 3'b010, 1'b0, 0, 0, 0);
        step("t6.c1000b",3'b100, 4'b0000, 1'b0, 4'b0000, 3'b000, 1'b0, 1000, 0, 1);
        step("t6.rejRet",3'b001, 4'b0000, 1'b1, 4'b0000, 3'b000, 1'b1, 1000, 1, 0);
        step("t6.chg2",  3'b000, 4'b0000, 1'b0, 4'b0000, 3'b100, 1'b0, 0, 0, 0);
        idle("t6.idle", 0, 0, 0);

        // Exact purchase drains credit and drops straight back to IDLE.
        step("tz.c500",  3'b010, 4'b0000, 1'b0, 4'b0000, 3'b000, 1'b0, 500, 0, 1);
        step("tz.sel",   3'b000, 4'b0010, 1'b0, 4'b0010, 3'b000, 1'b0, 0, 0, 0);
        idle("tz.idle", 0, 0, 0);

        // Timeout: an unaffordable select does not count as activity.
        for (int i = 0; i < 4; i++) begin
            step($sformatf("t4.c100_%0d", i), 3'b001, 4'b0000, 1'b0, 4'b0000, 3'b000, 1'b0,
                 31'(100 * (i + 1)), 0, 1);
        end
        for (int i = 0; i < 100; i++) begin
            if (i == 50) begin
                step("t4.selHigh", 3'b000, 4'b1000, 1'b0, 4'b0000, 3'b000, 1'b0, 400, 0, 1);
            end else begin
                idle($sformatf("t4.wait%0d", i), 400, 0, 1);
            end
        end
        idle("t4.enter", 400, 1, 0);
        for (int i = 0; i < 4; i++) begin
            step($sformatf("t4.chg%0d", i), 3'b000, 4'b0000, 1'b0, 4'b0000, 3'b001, 1'b0,
                 31'(300 - 100 * i), (i < 3) ? 1'b1 : 1'b0, 0);
        end
        idle("t4.idle", 0, 0, 0);

        // Select and coin together; the dispense reloads the timer for a full wait.
        for (int i = 0; i < 4; i++) begin
            step($sformatf("t5.c100_%0d", i), 3'b001, 4'b0000, 1'b0, 4'b0000, 3'b000, 1'b0,
                 31'(100 * (i + 1)), 0, 1);
        end
        step("t5.selCoin", 3'b001, 4'b0001, 1'b0, 4'b0001, 3'b000, 1'b0, 100, 0, 1);
        for (int i = 0; i < 100; i++) begin
            idle($sformatf("t5.wait%0d", i), 100, 0, 1);
        end
        idle("t5.enter", 100, 1, 0);
        step("t5.chg", 3'b000, 4'b0000, 1'b0, 4'b0000, 3'b001, 1'b0, 0, 0, 0);
        idle("t5.idle", 0, 0, 0);

        @(negedge clk);
        @(negedge clk);
        checkOutput("sb.drained", 32'(sb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
